// File: rtl/f_fetch_unit.sv
// f_fetch_unit: F-stage PC, instruction-memory handshake and IF/ID register with a one-entry skid buffer
module f_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_PC,
  input  logic        d_stall,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic [31:0] F_Pc4,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic        D_valid
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FULL} state_t;
  state_t state, state_n;
  logic [31:0] pc, skid_instr, skid_pc;
  logic d_free, d_accept, take, park, drain, load;
  assign im_req  = state == S_REQ;
  assign im_addr = pc;
  assign F_Pc4   = pc + 32'd4;
  always_comb begin
    d_free   = ~D_valid | ~d_stall;
    d_accept = D_valid & ~d_stall;
    take     = (state == S_REQ) & im_rvalid & d_free;
    park     = (state == S_REQ) & im_rvalid & ~d_free;
    drain    = (state == S_FULL) & d_free;
    load     = take | drain;
    state_n  = state == S_IDLE ? S_REQ : park ? S_FULL : drain ? S_REQ : state;
  end
  always_ff @(posedge clk)
    state <= !reset ? S_IDLE : state_n;
  // D_Instr/D_PC hold after E accepts so next-PC logic still sees the branch in D
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= RESET_PC;
      skid_instr <= '0;
      skid_pc    <= '0;
      D_Instr    <= '0;
      D_PC       <= '0;
      D_valid    <= 1'b0;
    end else begin
      if (load) pc <= next_PC;
      if (park) begin
        skid_instr <= im_rdata;
        skid_pc    <= pc;
      end
      if (load) begin
        D_Instr <= take ? im_rdata : skid_instr;
        D_PC    <= take ? pc : skid_pc;
      end
      D_valid <= load | (D_valid & ~d_accept);
    end
  end
endmodule

// File: tb/tb_f_fetch_unit.sv
// tb_f_fetch_unit: scoreboarded bench with a variable-latency memory model for f_fetch_unit
module tb_f_fetch_unit;
  logic clk, reset, d_stall, im_req, im_rvalid, D_valid;
  logic [31:0] next_PC, im_addr, im_rdata, F_Pc4, D_Instr, D_PC;
  logic jump_en, mem_on, mem_force;
  logic [31:0] jump_target, force_data;
  int lat, cnt, checks, failures, loads;
  typedef struct {logic [31:0] pc; logic [31:0] w;} ent_t;
  ent_t q[$];
  ent_t e;
  logic pv;
  logic [31:0] pi, ppc;

  f_fetch_unit dut (.clk(clk), .reset(reset), .next_PC(next_PC), .d_stall(d_stall),
    .im_req(im_req), .im_addr(im_addr), .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .F_Pc4(F_Pc4), .D_Instr(D_Instr), .D_PC(D_PC), .D_valid(D_valid));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign next_PC   = jump_en ? jump_target : F_Pc4;
  assign im_rvalid = mem_force | (mem_on & im_req & (cnt >= lat));
  assign im_rdata  = mem_force ? force_data : im_addr ^ 32'hA5A5_0000;

  // every accepted response is expected to reach D exactly once, in order
  always @(posedge clk) begin
    if (reset && im_req && im_rvalid) q.push_back('{pc: im_addr, w: im_rdata});
    cnt <= (!im_req || im_rvalid) ? 0 : cnt + 1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      pv = 1'b0;
    end else begin
      if (D_valid && (!pv || D_Instr !== pi || D_PC !== ppc)) begin
        loads++;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_load got_pc=%h got_instr=%h exp=none", D_PC, D_Instr);
        end else begin
          e = q.pop_front();
          if (D_PC !== e.pc || D_Instr !== e.w) begin
            failures++;
            $display("FAIL sb_load got_pc=%h got_instr=%h exp_pc=%h exp_instr=%h", D_PC, D_Instr, e.pc, e.w);
          end
        end
      end
      pv = D_valid; pi = D_Instr; ppc = D_PC;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; d_stall = 1'b0; jump_en = 1'b0; jump_target = '0;
    mem_on = 1'b0; mem_force = 1'b0; force_data = '0; lat = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (D_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%h exp=0", D_valid); end
      checks++; if (D_Instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", D_Instr); end
      checks++; if (D_PC !== 32'h0) begin failures++; $display("FAIL rst_dpc got=%h exp=0", D_PC); end
      checks++; if (F_Pc4 !== 32'h3004) begin failures++; $display("FAIL rst_pc4 got=%h exp=3004", F_Pc4); end
    end
    reset = 1'b1;
    checks++; if (im_req !== 1'b0) begin failures++; $display("FAIL idle_req got=%h exp=0", im_req); end
    step();
    checks++; if (im_req !== 1'b1) begin failures++; $display("FAIL first_req got=%h exp=1", im_req); end
    checks++; if (im_addr !== 32'h3000) begin failures++; $display("FAIL first_addr got=%h exp=3000", im_addr); end
  endtask

  task automatic test_straight();
    mem_on = 1'b1; lat = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (im_addr !== 32'h3000 + 4 * i) begin failures++; $display("FAIL line_addr got=%h exp=%h", im_addr, 32'h3000 + 4 * i); end
      step();
      checks++; if (D_PC !== 32'h3000 + 4 * i) begin failures++; $display("FAIL line_dpc got=%h exp=%h", D_PC, 32'h3000 + 4 * i); end
      checks++; if (D_valid !== 1'b1) begin failures++; $display("FAIL line_valid got=%h exp=1", D_valid); end
    end
  endtask

  task automatic test_jump();
    logic [31:0] a;
    a = im_addr;
    jump_en = 1'b1; jump_target = 32'h3100;
    step();
    jump_en = 1'b0;
    checks++; if (D_PC !== a) begin failures++; $display("FAIL slot_dpc got=%h exp=%h", D_PC, a); end
    checks++; if (im_addr !== 32'h3100) begin failures++; $display("FAIL jump_addr got=%h exp=3100", im_addr); end
    step();
    checks++; if (D_PC !== 32'h3100) begin failures++; $display("FAIL target_dpc got=%h exp=3100", D_PC); end
    checks++; if (im_addr !== 32'h3104) begin failures++; $display("FAIL target_next got=%h exp=3104", im_addr); end
  endtask

  task automatic test_park();
    d_stall = 1'b1; mem_on = 1'b0; mem_force = 1'b1; force_data = 32'h2401_0005;
    step();
    mem_force = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (im_req !== 1'b0) begin failures++; $display("FAIL park_req got=%h exp=0", im_req); end
      checks++; if (im_addr !== 32'h3104) begin failures++; $display("FAIL park_pc got=%h exp=3104", im_addr); end
      checks++; if (D_PC !== 32'h3100 || D_valid !== 1'b1) begin failures++; $display("FAIL park_hold got=%h/%h exp=3100/1", D_PC, D_valid); end
      if (i == 0) step();
    end
    d_stall = 1'b0; mem_on = 1'b1;
    step();
    checks++; if (D_Instr !== 32'h2401_0005) begin failures++; $display("FAIL unpark_instr got=%h exp=24010005", D_Instr); end
    checks++; if (D_PC !== 32'h3104 || D_valid !== 1'b1) begin failures++; $display("FAIL unpark_d got=%h/%h exp=3104/1", D_PC, D_valid); end
    checks++; if (im_req !== 1'b1 || im_addr !== 32'h3108) begin failures++; $display("FAIL unpark_req got=%h/%h exp=1/3108", im_req, im_addr); end
  endtask

  task automatic test_slow();
    logic [31:0] a, pinstr;
    lat = 2;
    for (int k = 0; k < 2; k++) begin
      a = 32'h3108 + 4 * k;
      pinstr = D_Instr;
      checks++; if (im_addr !== a) begin failures++; $display("FAIL slow_addr0 got=%h exp=%h", im_addr, a); end
      step();
      checks++; if (im_addr !== a) begin failures++; $display("FAIL slow_addr1 got=%h exp=%h", im_addr, a); end
      checks++; if (D_valid !== 1'b0) begin failures++; $display("FAIL slow_drop got=%h exp=0", D_valid); end
      checks++; if (D_Instr !== pinstr) begin failures++; $display("FAIL slow_hold got=%h exp=%h", D_Instr, pinstr); end
      step();
      checks++; if (im_addr !== a || im_req !== 1'b1) begin failures++; $display("FAIL slow_addr2 got=%h exp=%h", im_addr, a); end
      d_stall = 1'b1;
      step();
      d_stall = 1'b0;
      checks++; if (D_valid !== 1'b1 || D_PC !== a) begin failures++; $display("FAIL slow_load got=%h/%h exp=1/%h", D_valid, D_PC, a); end
      checks++; if (im_addr !== a + 4) begin failures++; $display("FAIL slow_next got=%h exp=%h", im_addr, a + 4); end
    end
  endtask

  task automatic test_wrap();
    lat = 0;
    jump_en = 1'b1; jump_target = 32'hFFFF_FFFC;
    step();
    jump_en = 1'b0;
    checks++; if (im_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr got=%h exp=fffffffc", im_addr); end
    checks++; if (F_Pc4 !== 32'h0) begin failures++; $display("FAIL wrap_pc4 got=%h exp=0", F_Pc4); end
    step();
    checks++; if (im_addr !== 32'h0 || D_PC !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_next got=%h/%h exp=0/fffffffc", im_addr, D_PC); end
  endtask

  task automatic test_back_to_back();
    int l0;
    l0 = loads;
    for (int i = 0; i < 300; i++) begin
      d_stall = $urandom_range(0, 3) == 0;
      lat = $urandom_range(0, 2);
      jump_target = 32'h5000 + ($urandom_range(0, 63) << 2);
      jump_en = ($urandom_range(0, 7) == 0) && (jump_target != im_addr);
      step();
    end
    d_stall = 1'b0; jump_en = 1'b0; lat = 0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (loads - l0 < 20) begin failures++; $display("FAIL b2b_progress got=%0d exp>=20", loads - l0); end
  endtask

  task automatic test_reset_mid();
    mem_on = 1'b0;
    step();
    checks++; if (im_req !== 1'b1) begin failures++; $display("FAIL mid_inreq got=%h exp=1", im_req); end
    reset = 1'b0;
    step();
    reset = 1'b1; mem_force = 1'b1; force_data = 32'hDEAD_BEEF;
    checks++; if (im_req !== 1'b0) begin failures++; $display("FAIL mid_idle got=%h exp=0", im_req); end
    step();
    mem_force = 1'b0;
    checks++; if (D_Instr !== 32'h0 || D_valid !== 1'b0) begin failures++; $display("FAIL mid_ignore got=%h/%h exp=0/0", D_Instr, D_valid); end
    checks++; if (im_req !== 1'b1 || im_addr !== 32'h3000) begin failures++; $display("FAIL mid_addr got=%h/%h exp=1/3000", im_req, im_addr); end
    step();
    checks++; if (q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", q.size()); end
  endtask

  initial begin
    checks = 0; failures = 0; loads = 0; pv = 1'b0; pi = '0; ppc = '0;
    test_reset();
    test_straight();
    test_jump();
    test_park();
    test_slow();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/f_fetch_unit.md
Name: f_fetch_unit

Overview:
- F-stage fetch engine for the P5 pipeline. It owns the F-stage PC register and exports F_Pc4 to the D-stage next-PC logic.
- It consumes next_PC back from that logic and runs a request/response handshake with instruction memory.
- It loads the IF/ID register (D_Instr, D_PC, D_valid) under the hazard unit's stall.
- Branch delay slot semantics: the instruction after a branch/jump is always fetched and issued.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset; first fetch address.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
next_PC  input  32  next fetch address from D-stage next-PC logic (function of F_Pc4 and D_Instr)
d_stall  input  1  hazard unit: D instruction may not advance to E this cycle
im_req  output  1  fetch request to instruction memory, level
im_addr  output  32  fetch address, equals PC register
im_rvalid  input  1  instruction memory response valid
im_rdata  input  32  instruction word, meaningful when im_rvalid=1
F_Pc4  output  32  PC register + 4 (combinational, 32-bit wrap)
D_Instr  output  32  IF/ID instruction register
D_PC  output  32  IF/ID PC register
D_valid  output  1  D_Instr not yet accepted by E

Behaviour:
- Registers: pc, state, skid buffer skid_instr/skid_pc, D_Instr, D_PC, D_valid.
- Reset (reset==0 at edge): pc<=RESET_PC, state<=S_IDLE, D_Instr<=0, D_PC<=0, D_valid<=0, skid<=0. Overrides all other events. Any response in flight is discarded.
- States:
  - S_IDLE: im_req=0; next state S_REQ. Always exactly one cycle after reset.
  - S_REQ: im_req=1, im_addr=pc; im_addr held stable until response. im_rvalid is accepted in any S_REQ cycle, including the first (zero-latency memory allowed).
  - S_FULL: im_req=0; skid buffer holds a fetched word that could not load into D.
- im_rvalid while not in S_REQ: ignored; no state change.
- d_accept = D_valid & ~d_stall (E takes D this cycle).
- d_free = ~D_valid | ~d_stall (D may be overwritten this cycle).
- Load event, in S_REQ with im_rvalid & d_free:
  - D_Instr<=im_rdata, D_PC<=pc, D_valid<=1.
  - pc<=next_PC (sampled that same cycle).
  - Stay in S_REQ; the new request is visible the next cycle.
- Park event, in S_REQ with im_rvalid & ~d_free:
  - skid_instr<=im_rdata, skid_pc<=pc, state<=S_FULL.
  - pc unchanged.
- In S_FULL with d_free:
  - D_Instr<=skid_instr, D_PC<=skid_pc, D_valid<=1.
  - pc<=next_PC, state<=S_REQ.
- In S_FULL with ~d_free: hold everything.
- No load this cycle and d_accept: D_valid<=0. D_Instr/D_PC hold their values; next-PC logic must still see the last instruction.
- Delay slot: a branch stays in D until its delay-slot word loads. next_PC at that load is the branch/jump target. No flush, no squash.
- Latency:
  - Zero-wait memory (im_rvalid in first S_REQ cycle) with d_stall=0 gives one instruction per cycle.
  - An N-cycle memory gives one instruction per N cycles.
- At most one outstanding request; at most one skid entry.
- Arithmetic:
  - F_Pc4 = pc + 32'd4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - next_PC is loaded as given, with no alignment check.
- d_stall only blocks D replacement while D_valid=1. With D_valid=0, a response always loads.

Test Plan:
1. Reset: reset=0 for 2 cycles, then 1 -> during reset D_valid=0, D_Instr=0, D_PC=0, F_Pc4=32'h3004; first cycle after im_req=0; second cycle im_req=1, im_addr=32'h3000.
2. Straight line, zero-wait memory, d_stall=0, next_PC=F_Pc4 -> im_addr 3000,3004,3008 on consecutive cycles; D_PC follows one cycle later; D_valid stays 1.
3. Jump with delay slot: D_Instr=jal at D_PC=32'h3000, next_PC=32'h3100 when word at 3004 returns -> D_PC=32'h3004, next im_addr=32'h3100.
4. Stall park: D_valid=1, d_stall=1, im_rvalid with im_rdata=32'h2401_0005 -> state S_FULL, im_req=0, pc and D unchanged; d_stall drops -> D_Instr=32'h2401_0005, D_valid=1, im_req=1 at next_PC one cycle later.
5. 3-cycle memory, d_stall=0 -> im_addr stable for 3 cycles; D_valid falls to 0 one cycle after the issue while D_Instr holds; load restores D_valid=1.
6. Reset mid-fetch: reset=0 in S_REQ, im_rvalid=1 with 32'hDEAD_BEEF in the following S_IDLE cycle -> word ignored, D_Instr=0, im_addr=32'h3000.
